class_accum_ctrl: RTL

CLASS_ACCUM_CTRL -- requirements
Module: class_accum_ctrl

---
 rtl/hdc_pkg.sv | 8 +
 rtl/class_accum_ctrl_if.sv | 24 ++
 rtl/class_sat_adder.sv | 23 ++
 rtl/class_accum_ctrl.sv | 75 +++++++
 4 files changed

// File: rtl/hdc_pkg.sv
// hdc_pkg: shared defaults and FSM state encoding for the class accumulator.
package hdc_pkg;
    localparam int DEF_CHUNK_W    = 5;
    localparam int DEF_NUM_CHUNKS = 10;
    localparam int DEF_CNT_W      = 8;
    localparam int DEF_THRESHOLD  = 30;
    typedef enum logic [1:0] {IDLE, ACCUM, CLEAR} state_t;
endpackage

// File: rtl/class_accum_ctrl_if.sv
// class_accum_ctrl_if: chunk input, clear, readout and status bundle.
interface class_accum_ctrl_if #(
    parameter int CHUNK_W = 5,
    parameter int CNT_W   = 8
);
    logic                       in_valid;
    logic                       in_ready;
    logic [CHUNK_W-1:0]         in_chunk;
    logic                       clear;
    logic                       rd_en;
    logic [3:0]                 rd_idx;
    logic [CHUNK_W*CNT_W-1:0]   rd_data;
    logic                       hv_done;
    logic [7:0]                 hv_count;
    logic                       busy;
    modport master (
        output in_valid, in_chunk, clear, rd_en, rd_idx,
        input  in_ready, rd_data, hv_done, hv_count, busy
    );
    modport slave (
        input  in_valid, in_chunk, clear, rd_en, rd_idx,
        output in_ready, rd_data, hv_done, hv_count, busy
    );
endinterface

// File: rtl/class_sat_adder.sv
// class_sat_adder: adds one chunk bit to each lane counter of a row.
// CLASS_ACCUM_SAT_EN caps lanes at THRESHOLD; otherwise lanes wrap.
module class_sat_adder import hdc_pkg::*; #(
    parameter int CHUNK_W   = DEF_CHUNK_W,
    parameter int CNT_W     = DEF_CNT_W,
    parameter int THRESHOLD = DEF_THRESHOLD
) (
    input  logic [CHUNK_W*CNT_W-1:0] i_row,
    input  logic [CHUNK_W-1:0]       i_bits,
    output logic [CHUNK_W*CNT_W-1:0] o_row
);
`ifdef CLASS_ACCUM_SAT_EN
    localparam bit SAT = 1'b1;
`else
    localparam bit SAT = 1'b0;
`endif
    for (genvar l = 0; l < CHUNK_W; l++) begin : g_lane
        logic [CNT_W-1:0] w_a;
        assign w_a = i_row[l*CNT_W +: CNT_W];
        assign o_row[l*CNT_W +: CNT_W] =
            (i_bits[l] && !(SAT && w_a >= CNT_W'(THRESHOLD))) ? w_a + CNT_W'(1) : w_a;
    end
endmodule

// File: rtl/class_accum_ctrl.sv
// class_accum_ctrl: per-lane hypervector accumulator with clear sweep and row readout.
// Define CLASS_ACCUM_SAT_EN to saturate lanes at THRESHOLD instead of wrapping.
module class_accum_ctrl import hdc_pkg::*; #(
    parameter int CHUNK_W    = DEF_CHUNK_W,
    parameter int NUM_CHUNKS = DEF_NUM_CHUNKS,
    parameter int CNT_W      = DEF_CNT_W,
    parameter int THRESHOLD  = DEF_THRESHOLD
) (
    input logic               clk,
    input logic               rst,
    class_accum_ctrl_if.slave bus
);
    localparam int         ROW_W = CHUNK_W * CNT_W;
    localparam logic [3:0] LAST  = 4'(NUM_CHUNKS - 1);
    state_t           r_state;
    logic [3:0]       r_idx, r_sweep;
    logic [ROW_W-1:0] r_rows [NUM_CHUNKS];
    logic [ROW_W-1:0] r_rd, w_cur, w_sum, w_rd;
    logic             r_done, r_busy, w_acc;
    logic [7:0]       r_hv;
    assign bus.in_ready = r_state != CLEAR;
    assign bus.rd_data  = r_rd;
    assign bus.hv_done  = r_done;
    assign bus.hv_count = r_hv;
    assign bus.busy     = r_busy;
    // clear wins over a same-cycle accept
    assign w_acc = bus.in_valid && bus.in_ready && !bus.clear;
    always_comb begin
        w_cur = '0;
        w_rd  = '0;
        for (int i = 0; i < NUM_CHUNKS; i++) begin
            if (r_idx == 4'(i)) w_cur = r_rows[i];
            if (bus.rd_idx == 4'(i)) w_rd = r_rows[i];
        end
    end
    class_sat_adder #(.CHUNK_W(CHUNK_W), .CNT_W(CNT_W), .THRESHOLD(THRESHOLD)) u_add (
        .i_row  (w_cur),
        .i_bits (bus.in_chunk),
        .o_row  (w_sum)
    );
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
            r_idx   <= '0;
            r_sweep <= '0;
            r_done  <= 1'b0;
            r_busy  <= 1'b0;
            r_hv    <= '0;
            r_rd    <= '0;
            for (int i = 0; i < NUM_CHUNKS; i++) r_rows[i] <= '0;
        end else begin
            r_done <= 1'b0;
            if (bus.rd_en) r_rd <= w_rd;
            for (int i = 0; i < NUM_CHUNKS; i++)
                if (!bus.clear && r_state == CLEAR && r_sweep == 4'(i)) r_rows[i] <= '0;
                else if (w_acc && r_idx == 4'(i)) r_rows[i] <= w_sum;
            if (bus.clear) begin
                r_state <= CLEAR;
                r_idx   <= '0;
                r_sweep <= '0;
                r_hv    <= '0;
                r_busy  <= 1'b1;
            end else if (r_state == CLEAR) begin
                r_sweep <= r_sweep + 4'd1;
                r_state <= r_sweep == LAST ? IDLE : CLEAR;
                r_busy  <= r_sweep != LAST;
            end else if (w_acc) begin
                r_idx   <= r_idx == LAST ? 4'd0 : r_idx + 4'd1;
                r_state <= r_idx == LAST ? IDLE : ACCUM;
                r_done  <= r_idx == LAST;
                r_hv    <= (r_idx == LAST && r_hv != 8'hFF) ? r_hv + 8'd1 : r_hv;
            end
        end
    end
endmodule
